hacd_axi_ram: RTL and testbench

AXI4 slave memory responder that terminates one master port of the HACD AXI crossbar. It accepts write and read bursts (FIXED, INCR, WRAP), stores data in an internal byte-strobed array, and returns B and R responses carrying the crossbar-extended ID. It serves as the on-chip backing store for HACD compressed-page metadata and as the crossbar's downstream target in block-level simulation.

---
 rtl/hacd_axi_ram_if.sv | 68 ++++++
 rtl/hacd_axi_ram.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_hacd_axi_ram.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hacd_axi_ram_if.sv
// AXI4 bus bundle between the HACD crossbar master port and hacd_axi_ram.
// Lock/cache/prot/qos/region/user are intentionally absent.

`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

interface hacd_axi_ram_if #(
    parameter int unsigned DATA_WIDTH = `HACD_AXI4_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = `HACD_AXI4_ID_WIDTH + 1
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/hacd_axi_ram.sv
// AXI4 slave RAM with independent write/read burst engines (FIXED/INCR/WRAP).
// Define HACD_AXI_RAM_RD_PIPE_EN to add a registered R output stage with a 2-entry skid.

`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

module hacd_axi_ram #(
    parameter int unsigned DATA_WIDTH = `HACD_AXI4_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = `HACD_AXI4_ID_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst,
    hacd_axi_ram_if.slave s_axi
);

    localparam int unsigned AddrLsb = $clog2(STRB_WIDTH);
    localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;
    localparam int unsigned Depth   = 1 << IdxW;

    // Oversized beats are clamped to the bus width before stepping.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [2:0]            sz;
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] wmask;
        sz    = (size > 3'(AddrLsb)) ? 3'(AddrLsb) : size;
        inc   = addr + (ADDR_WIDTH'(1) << sz);
        wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~wmask) | (inc & wmask);
            default: return inc;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [Depth];

    // ------------------------------------------------------------------ write engine
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic                  w_err_q, w_err_d;
    logic                  w_last_beat;
    logic                  w_err_nxt;
    logic                  mem_we;

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_err_nxt   = w_err_q | (s_axi.wlast != w_last_beat);

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                awready_d = 1'b1;
                if (s_axi.awvalid && awready_q) begin
                    w_id_d    = s_axi.awid;
                    w_addr_d  = s_axi.awaddr;
                    w_len_d   = s_axi.awlen;
                    w_size_d  = s_axi.awsize;
                    w_burst_d = s_axi.awburst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (s_axi.wvalid && wready_q) begin
                    mem_we   = 1'b1;
                    w_err_d  = w_err_nxt;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = w_err_nxt ? 2'b10 : 2'b00;
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (s_axi.bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'b00;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    // Array contents survive reset; only the beat itself is suppressed.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[w_addr_q[ADDR_WIDTH-1:AddrLsb]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;

    // ------------------------------------------------------------------ read engine
    typedef enum logic {RIdle, RData} r_state_e;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [ADDR_WIDTH-1:0] r_nxt_addr;
    logic [IdxW-1:0]       rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign r_nxt_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    // Old data wins on a same-word collision: the read samples before the write lands.
    assign rd_word    = mem[rd_idx];

`ifdef HACD_AXI_RAM_RD_PIPE_EN
    // r_addr_q is the address of the next beat to issue into the s1 stage.
    logic [8:0]            r_iss_q, r_iss_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0] f_data_q [2];
    logic [DATA_WIDTH-1:0] f_data_d [2];
    logic [1:0]            f_last_q, f_last_d;
    logic                  f_wr_ptr_q, f_wr_ptr_d;
    logic                  f_rd_ptr_q, f_rd_ptr_d;
    logic [1:0]            f_cnt_q, f_cnt_d;
    logic                  push, pop, r_issue;
    logic [1:0]            occ;

    assign rd_idx  = (r_state_q == RIdle) ? s_axi.araddr[ADDR_WIDTH-1:AddrLsb]
                                          : r_addr_q[ADDR_WIDTH-1:AddrLsb];
    assign push    = s1_valid_q;
    assign pop     = (f_cnt_q != 2'd0) && s_axi.rready;
    // s1 plus skid never hold more than two beats, so a push always fits.
    assign occ     = f_cnt_q + {1'b0, s1_valid_q} - {1'b0, pop};
    assign r_issue = (r_state_q == RData) && (r_iss_q <= {1'b0, r_len_q}) && (occ <= 2'd1);

    always_comb begin
        r_state_d  = r_state_q;
        arready_d  = arready_q;
        rid_d      = rid_q;
        r_addr_d   = r_addr_q;
        r_len_d    = r_len_q;
        r_size_d   = r_size_q;
        r_burst_d  = r_burst_q;
        r_iss_d    = r_iss_q;
        s1_valid_d = 1'b0;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        f_data_d   = f_data_q;
        f_last_d   = f_last_q;
        f_wr_ptr_d = f_wr_ptr_q;
        f_rd_ptr_d = f_rd_ptr_q;
        f_cnt_d    = f_cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            f_data_d[f_wr_ptr_q] = s1_data_q;
            f_last_d[f_wr_ptr_q] = s1_last_q;
            f_wr_ptr_d           = ~f_wr_ptr_q;
        end
        if (pop) f_rd_ptr_d = ~f_rd_ptr_q;
        unique case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (s_axi.arvalid && arready_q) begin
                    rid_d      = s_axi.arid;
                    r_len_d    = s_axi.arlen;
                    r_size_d   = s_axi.arsize;
                    r_burst_d  = s_axi.arburst;
                    r_addr_d   = next_addr(s_axi.araddr, s_axi.arlen, s_axi.arsize,
                                           s_axi.arburst);
                    r_iss_d    = 9'd1;
                    s1_valid_d = 1'b1;
                    s1_data_d  = rd_word;
                    s1_last_d  = (s_axi.arlen == 8'd0);
                    arready_d  = 1'b0;
                    r_state_d  = RData;
                end
            end
            RData: begin
                if (r_issue) begin
                    s1_valid_d = 1'b1;
                    s1_data_d  = rd_word;
                    s1_last_d  = (r_iss_q == {1'b0, r_len_q});
                    r_addr_d   = r_nxt_addr;
                    r_iss_d    = r_iss_q + 9'd1;
                end
                if (pop && f_last_q[f_rd_ptr_q]) begin
                    arready_d = 1'b1;
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= RIdle;
            arready_q  <= 1'b0;
            rid_q      <= '0;
            r_addr_q   <= '0;
            r_len_q    <= 8'd0;
            r_size_q   <= 3'd0;
            r_burst_q  <= 2'b00;
            r_iss_q    <= 9'd0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            f_data_q   <= '{default: '0};
            f_last_q   <= 2'b00;
            f_wr_ptr_q <= 1'b0;
            f_rd_ptr_q <= 1'b0;
            f_cnt_q    <= 2'd0;
        end else begin
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rid_q      <= rid_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_iss_q    <= r_iss_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            f_data_q   <= f_data_d;
            f_last_q   <= f_last_d;
            f_wr_ptr_q <= f_wr_ptr_d;
            f_rd_ptr_q <= f_rd_ptr_d;
            f_cnt_q    <= f_cnt_d;
        end
    end

    assign s_axi.rvalid = (f_cnt_q != 2'd0);
    assign s_axi.rdata  = f_data_q[f_rd_ptr_q];
    assign s_axi.rlast  = f_last_q[f_rd_ptr_q];
`else
    // r_addr_q is the address of the beat currently presented on R.
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]            r_cnt_q, r_cnt_d;

    assign rd_idx = (r_state_q == RIdle) ? s_axi.araddr[ADDR_WIDTH-1:AddrLsb]
                                         : r_nxt_addr[ADDR_WIDTH-1:AddrLsb];

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rid_d     = rid_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (s_axi.arvalid && arready_q) begin
                    rid_d     = s_axi.arid;
                    r_addr_d  = s_axi.araddr;
                    r_len_d   = s_axi.arlen;
                    r_size_d  = s_axi.arsize;
                    r_burst_d = s_axi.arburst;
                    r_cnt_d   = 8'd0;
                    rdata_d   = rd_word;
                    rvalid_d  = 1'b1;
                    rlast_d   = (s_axi.arlen == 8'd0);
                    arready_d = 1'b0;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (rvalid_q && s_axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = RIdle;
                    end else begin
                        r_addr_d = r_nxt_addr;
                        rdata_d  = rd_word;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rid_q     <= '0;
            r_addr_q  <= '0;
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'b00;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            r_cnt_q   <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rid_q     <= rid_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rdata  = rdata_q;
    assign s_axi.rlast  = rlast_q;
`endif

    assign s_axi.arready = arready_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = 2'b00;

endmodule

// File: tb/tb_hacd_axi_ram.sv
// Directed self-checking bench for hacd_axi_ram: bursts, strobes, wrap, backpressure,
// write protocol error and mid-burst reset.

`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

module tb_hacd_axi_ram;

    localparam int unsigned DW  = `HACD_AXI4_DATA_WIDTH;
    localparam int unsigned AW  = 16;
    localparam int unsigned IDW = `HACD_AXI4_ID_WIDTH + 1;
    localparam int unsigned SB  = DW / 8;
    localparam logic [2:0]  SzFull = 3'($clog2(SB));
    localparam int          Tmo = 64;
`ifdef HACD_AXI_RAM_RD_PIPE_EN
    localparam int RdLat = 2;
`else
    localparam int RdLat = 1;
`endif

    typedef logic [DW-1:0] data_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hacd_axi_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) ram_if ();

    hacd_axi_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SB),
        .ID_WIDTH  (IDW)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .s_axi(ram_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    data_t          wr_buf [16];
    data_t          rd_buf [16];
    logic [1:0]     bresp_o;
    logic [IDW-1:0] bid_o;
    int             aw2w, w2b, rd_lat;

    task automatic check_eq(input string tag, input data_t got, input data_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic data_t pat(input logic [31:0] base, input int i);
        return {(DW/32){base + 32'(i)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [SB-1:0] strb, input int lastpos);
        int n;
        ram_if.awid    = id;
        ram_if.awaddr  = addr;
        ram_if.awlen   = len;
        ram_if.awsize  = SzFull;
        ram_if.awburst = burst;
        ram_if.awvalid = 1'b1;
        n = 0;
        while (!ram_if.awready && n < Tmo) begin step(); n++; end
        check_eq("aw_accept", data_t'(n < Tmo), data_t'(1));
        step();
        ram_if.awvalid = 1'b0;
        aw2w = 1;
        while (!ram_if.wready && aw2w < Tmo) begin step(); aw2w++; end
        for (int i = 0; i <= int'(len); i++) begin
            ram_if.wdata  = wr_buf[i];
            ram_if.wstrb  = strb;
            ram_if.wlast  = (i == lastpos);
            ram_if.wvalid = 1'b1;
            n = 0;
            while (!ram_if.wready && n < Tmo) begin step(); n++; end
            step();
        end
        ram_if.wvalid = 1'b0;
        ram_if.wlast  = 1'b0;
        w2b = 1;
        while (!ram_if.bvalid && w2b < Tmo) begin step(); w2b++; end
        check_eq("b_seen", data_t'(ram_if.bvalid), data_t'(1));
        bid_o   = ram_if.bid;
        bresp_o = ram_if.bresp;
        ram_if.bready = 1'b1;
        step();
        ram_if.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input bit toggle);
        int    n, beat, cyc;
        bit    stalled;
        data_t held;
        logic  held_last;
        ram_if.arid    = id;
        ram_if.araddr  = addr;
        ram_if.arlen   = len;
        ram_if.arsize  = SzFull;
        ram_if.arburst = burst;
        ram_if.arvalid = 1'b1;
        n = 0;
        while (!ram_if.arready && n < Tmo) begin step(); n++; end
        step();
        ram_if.arvalid = 1'b0;
        rd_lat = 1;
        while (!ram_if.rvalid && rd_lat < Tmo) begin step(); rd_lat++; end
        beat      = 0;
        cyc       = 0;
        stalled   = 1'b0;
        held      = '0;
        held_last = 1'b0;
        while (beat <= int'(len) && cyc < Tmo) begin
            ram_if.rready = !toggle || (cyc % 2 == 0);
            if (stalled) begin
                check_eq("r_hold_data", ram_if.rdata, held);
                check_eq("r_hold_last", data_t'(ram_if.rlast), data_t'(held_last));
            end
            stalled = 1'b0;
            if (ram_if.rvalid) begin
                if (ram_if.rready) begin
                    rd_buf[beat] = ram_if.rdata;
                    check_eq("r_last", data_t'(ram_if.rlast), data_t'(beat == int'(len)));
                    check_eq("r_id", data_t'(ram_if.rid), data_t'(id));
                    beat++;
                end else begin
                    held      = ram_if.rdata;
                    held_last = ram_if.rlast;
                    stalled   = 1'b1;
                end
            end
            step();
            cyc++;
        end
        ram_if.rready = 1'b0;
        check_eq("r_beats", data_t'(beat), data_t'(int'(len) + 1));
    endtask

    initial begin
        int    got, n;
        data_t exp;
        ram_if.awid = '0;  ram_if.awaddr = '0; ram_if.awlen = '0; ram_if.awsize = '0;
        ram_if.awburst = '0; ram_if.awvalid = 1'b0;
        ram_if.wdata = '0; ram_if.wstrb = '0;  ram_if.wlast = 1'b0; ram_if.wvalid = 1'b0;
        ram_if.bready = 1'b0;
        ram_if.arid = '0;  ram_if.araddr = '0; ram_if.arlen = '0; ram_if.arsize = '0;
        ram_if.arburst = '0; ram_if.arvalid = 1'b0;
        ram_if.rready = 1'b0;

        // Reset values, then ready rises the first cycle out of reset.
        repeat (3) step();
        check_eq("rst_awready", data_t'(ram_if.awready), '0);
        check_eq("rst_arready", data_t'(ram_if.arready), '0);
        check_eq("rst_wready", data_t'(ram_if.wready), '0);
        check_eq("rst_bvalid", data_t'(ram_if.bvalid), '0);
        check_eq("rst_rvalid", data_t'(ram_if.rvalid), '0);
        check_eq("rst_rlast", data_t'(ram_if.rlast), '0);
        check_eq("rst_rdata", ram_if.rdata, '0);
        rst = 1'b0;
        step();
        check_eq("post_rst_awready", data_t'(ram_if.awready), data_t'(1));
        check_eq("post_rst_arready", data_t'(ram_if.arready), data_t'(1));

        // Single beat write + read.
        wr_buf[0] = {(DW/32){32'hDEADBEEF}};
        axi_write(5'h0A, 16'h0040, 8'd0, 2'b01, {SB{1'b1}}, 0);
        check_eq("single_bresp", data_t'(bresp_o), '0);
        check_eq("single_bid", data_t'(bid_o), data_t'(5'h0A));
        check_eq("aw_to_wready", data_t'(aw2w), data_t'(1));
        check_eq("w_to_bvalid", data_t'(w2b), data_t'(1));
        axi_read(5'h13, 16'h0040, 8'd0, 2'b01, 1'b0);
        check_eq("single_rdata", rd_buf[0], {(DW/32){32'hDEADBEEF}});
        check_eq("ar_to_rvalid", data_t'(rd_lat), data_t'(RdLat));

        // Byte strobes.
        wr_buf[0] = {SB{8'h11}};
        axi_write(5'h01, 16'h0080, 8'd0, 2'b01, {SB{1'b1}}, 0);
        wr_buf[0] = {SB{8'hFF}};
        axi_write(5'h01, 16'h0080, 8'd0, 2'b01, SB'(1), 0);
        axi_read(5'h01, 16'h0080, 8'd0, 2'b01, 1'b0);
        exp = {SB{8'h11}};
        exp[7:0] = 8'hFF;
        check_eq("strobe_byte0", rd_buf[0], exp);

        // WRAP from word 2 of a 4-word block at 0x100 lands A0..A3 in words 2,3,0,1.
        for (int i = 0; i < 4; i++) wr_buf[i] = pat(32'hA0A00000, i);
        axi_write(5'h02, 16'h0100 + 16'(2 * SB), 8'd3, 2'b10, {SB{1'b1}}, 3);
        check_eq("wrap_bresp", data_t'(bresp_o), '0);
        axi_read(5'h02, 16'h0100, 8'd3, 2'b01, 1'b0);
        check_eq("wrap_w0", rd_buf[0], pat(32'hA0A00000, 2));
        check_eq("wrap_w1", rd_buf[1], pat(32'hA0A00000, 3));
        check_eq("wrap_w2", rd_buf[2], pat(32'hA0A00000, 0));
        check_eq("wrap_w3", rd_buf[3], pat(32'hA0A00000, 1));
        axi_read(5'h03, 16'h0100 + 16'(2 * SB), 8'd3, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("wrap_rd", rd_buf[i], pat(32'hA0A00000, i));

        // FIXED: four writes to one word, the last one wins.
        for (int i = 0; i < 4; i++) wr_buf[i] = pat(32'hB0B00000, i);
        axi_write(5'h04, 16'h0200, 8'd3, 2'b00, {SB{1'b1}}, 3);
        axi_read(5'h04, 16'h0200, 8'd0, 2'b01, 1'b0);
        check_eq("fixed_last_wins", rd_buf[0], pat(32'hB0B00000, 3));

        // INCR len=7 read under 1010 rready backpressure.
        for (int i = 0; i < 8; i++) wr_buf[i] = pat(32'hC0DE0000, i);
        axi_write(5'h05, 16'h0300, 8'd7, 2'b01, {SB{1'b1}}, 7);
        axi_read(5'h06, 16'h0300, 8'd7, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++) check_eq("bp_beat", rd_buf[i], pat(32'hC0DE0000, i));

        // Early wlast: SLVERR, data still written.
        for (int i = 0; i < 4; i++) wr_buf[i] = pat(32'hE0E00000, i);
        axi_write(5'h07, 16'h0400, 8'd3, 2'b01, {SB{1'b1}}, 1);
        check_eq("err_bresp", data_t'(bresp_o), data_t'(2'b10));
        check_eq("err_bid", data_t'(bid_o), data_t'(5'h07));
        axi_read(5'h07, 16'h0400, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("err_data", rd_buf[i], pat(32'hE0E00000, i));

        // Reset during beat 2 of a len=7 read.
        ram_if.arid = 5'h08; ram_if.araddr = 16'h0300; ram_if.arlen = 8'd7;
        ram_if.arsize = SzFull; ram_if.arburst = 2'b01; ram_if.arvalid = 1'b1;
        n = 0;
        while (!ram_if.arready && n < Tmo) begin step(); n++; end
        step();
        ram_if.arvalid = 1'b0;
        ram_if.rready  = 1'b1;
        got = 0;
        n   = 0;
        while (got < 2 && n < Tmo) begin
            if (ram_if.rvalid) got++;
            step();
            n++;
        end
        check_eq("rst_mid_beats", data_t'(got), data_t'(2));
        rst = 1'b1;
        ram_if.rready = 1'b0;
        step();
        check_eq("rst_mid_rvalid", data_t'(ram_if.rvalid), '0);
        check_eq("rst_mid_arready", data_t'(ram_if.arready), '0);
        rst = 1'b0;
        step();
        check_eq("rst_mid_arready_up", data_t'(ram_if.arready), data_t'(1));
        axi_read(5'h09, 16'h0300, 8'd7, 2'b01, 1'b0);
        for (int i = 0; i < 8; i++) check_eq("retained", rd_buf[i], pat(32'hC0DE0000, i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
